id_stage_pipe: RTL and testbench
================================

// Module: id_stage_pipe
// PURPOSE
//  Parametrised decode stage between the IF/ID register and EXE. It contains:
//   - an opcode decoder and control unit (adds addi, ori and illegal-opcode detection);
//   - an NREGS x XLEN register file with r0 hardwired to zero;
//   - a load-use hazard detector that stalls IF;
//   - an ID/EXE pipeline register with valid, stall-bubble and flush.
//  Downstream EXE/MEM/WB consume the ex_* outputs. WB writes back through wb_*.
// PARAMETERS
//  XLEN   32  datapath width (>=32); immediates extend to XLEN.
//  NREGS  32  register count (power of 2, 2..32).
//  AW     $clog2(NREGS)  register address width (derived; do not override).
// PORTS
//  clk          in   1     single clock, rising edge.
//  rst          in   1     reset, asynchronous, active-low.
//  if_valid     in   1     IF/ID holds a valid instruction.
//  if_instr     in   32    instruction word from IF/ID.
//  if_pc        in   XLEN  PC+4 from IF/ID.
//  flush_in     in   1     branch/jump taken in EXE; kill the instruction in ID.
//  wb_we        in   1     WB register write enable.
//  wb_dst       in   AW    WB destination register.
//  wb_data      in   XLEN  WB write data.
//  stall_out    out  1     hold PC and IF/ID this cycle (combinational).
//  ex_valid     out  1     ID/EXE slot holds a real instruction.
//  ex_ctrl      out  12    {RegDst,ALUsrc,Branch,Jump,MemWrite,MemRead,MemToReg,RegWrite,ALUop[1:0],Illegal,ExtOp}.
//  ex_rs_data   out  XLEN  rs operand.
//  ex_rt_data   out  XLEN  rt operand.
//  ex_imm       out  XLEN  extended immediate.
//  ex_pc        out  XLEN  PC+4 passthrough.
//  ex_rs_add / ex_rt_add / ex_rd_add  out  AW  register addresses (for EXE forwarding and dest select).
//  ex_shamt     out  5     shift amount.
//  ex_jaddr     out  26    J-type target field.
// BEHAVIOUR
//  - Reset (rst=0, async): every ex_* output is 0, all registers are 0, stall_out=0.
//  - Register fields are taken from if_instr[25:21]/[20:16]/[15:11] and truncated to AW bits.
//  - Decode (ALUop, RegDst, ALUsrc, Branch, Jump, MemWrite, MemRead, MemToReg, RegWrite, ExtOp):
//      R 000000   = 10 1 0 0 0 0 0 0 1 0
//      lw 100011  = 00 0 1 0 0 0 1 1 1 1
//      sw 101011  = 00 0 1 0 0 1 0 0 0 1
//      beq 000100 = 01 0 0 1 0 0 0 0 0 1
//      j 000010   = 00 0 0 0 1 0 0 0 0 0
//      addi 001000 = 00 0 1 0 0 0 0 0 1 1
//      ori 001101 = 11 0 1 0 0 0 0 0 1 0
//      other opcodes: all controls 0, Illegal=1 (no register or memory side effect).
//  - ExtOp=1 sign-extends imm[15:0] to XLEN; ExtOp=0 zero-extends.
//  - Regfile: 2 combinational reads, 1 synchronous write on posedge clk when wb_we && wb_dst!=0.
//    Reads of r0 always return 0.
//  - Hazard condition haz: ex_valid && ex_ctrl.MemRead && ex_rt_add!=0 && if_valid &&
//    (ex_rt_add==rs || (ex_rt_add==rt && opcode in {R, sw, beq})).
//  - Each posedge clk, priority order:
//      1. flush_in=1: load bubble (ex_valid=0, ex_ctrl=0); stall_out=0.
//      2. haz=1: load bubble; stall_out=1.
//      3. otherwise: load decoded fields; ex_valid=if_valid.
//    Data fields of a bubble are don't-care but are driven to 0.
//  - Latency: 1 cycle from IF/ID to ex_*. A load-use pair costs exactly 1 bubble.
//  - Simultaneous flush_in and haz: flush wins and stall_out=0.
//  - rst asserted mid-stall clears the stall immediately.
// CONFIGURATION
//  REGFILE_BYPASS_EN defined:
//    - when wb_we && wb_dst!=0 && wb_dst==rs (or rt), that operand reads wb_data in the same cycle.
//  Not defined:
//    - reads return the array contents (old value).
//    - haz additionally asserts when wb_we && wb_dst!=0 && wb_dst matches rs or rt, giving a 1-cycle stall.
// STRUCTURE
//  Package id_pkg holds:
//    - opcode localparams (OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_ORI);
//    - ALUop encodings;
//    - a ctrl_t packed struct and its field order (shared with the EXE stage).
//  Sub-module id_regfile (params XLEN, NREGS) holds the array, r0 rule and optional bypass.
//  Decode, hazard detection and the ID/EXE register stay in the top.
// TESTING
//  1. Reset with rst=0 while clocking -> all ex_*=0, stall_out=0; read r5 after reset -> 0.
//  2. WB writes r3=0x1234, then add r4,r3,r3 (0x00632020) -> ex_rs_data=ex_rt_data=0x1234, ex_ctrl.ALUop=10.
//  3. lw r2,0(r1), then add r5,r2,r0 -> stall_out=1 for 1 cycle, one bubble (ex_valid=0), then the add issues.
//  4. Same cycle: WB writes r7=0xA5 and ID reads r7 -> 0xA5 with bypass; without it, stall_out=1 and 0xA5 next cycle.
//  5. ori imm 0x8000 -> ex_imm=0x00008000; addi imm 0x8000 -> ex_imm=0xFFFF8000; opcode 111111 -> Illegal=1, RegWrite=0.
//  6. flush_in=1 together with a load-use hazard -> bubble, stall_out=0; a write to r0 -> r0 still reads 0.

Source files
------------

// File: rtl/id_pkg.sv
// Shared decode definitions for the ID stage and EXE consumers: opcodes, ALUop
// encodings, the control-word layout and the opcode decoder.
package id_pkg;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_ORI  = 6'b001101;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;
   localparam logic [1:0] ALUOP_OR    = 2'b11;

   // Field order is fixed: EXE slices this word by position.
   typedef struct packed {
      logic       reg_dst;
      logic       alu_src;
      logic       branch;
      logic       jump;
      logic       mem_write;
      logic       mem_read;
      logic       mem_to_reg;
      logic       reg_write;
      logic [1:0] alu_op;
      logic       illegal;
      logic       ext_op;
   } ctrl_t;

   function automatic ctrl_t decode_op(input logic [5:0] op);
      ctrl_t c;
      c = '0;
      case (op)
         OP_R: begin
            c.alu_op    = ALUOP_FUNCT;
            c.reg_dst   = 1'b1;
            c.reg_write = 1'b1;
         end
         OP_LW: begin
            c.alu_op     = ALUOP_ADD;
            c.alu_src    = 1'b1;
            c.mem_read   = 1'b1;
            c.mem_to_reg = 1'b1;
            c.reg_write  = 1'b1;
            c.ext_op     = 1'b1;
         end
         OP_SW: begin
            c.alu_op    = ALUOP_ADD;
            c.alu_src   = 1'b1;
            c.mem_write = 1'b1;
            c.ext_op    = 1'b1;
         end
         OP_BEQ: begin
            c.alu_op = ALUOP_SUB;
            c.branch = 1'b1;
            c.ext_op = 1'b1;
         end
         OP_J: begin
            c.jump = 1'b1;
         end
         OP_ADDI: begin
            c.alu_op    = ALUOP_ADD;
            c.alu_src   = 1'b1;
            c.reg_write = 1'b1;
            c.ext_op    = 1'b1;
         end
         OP_ORI: begin
            c.alu_op    = ALUOP_OR;
            c.alu_src   = 1'b1;
            c.reg_write = 1'b1;
         end
         // Unknown opcodes carry no side effects, only the illegal flag.
         default: c.illegal = 1'b1;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/id_regfile.sv
// NREGS x XLEN register file: two combinational reads, one synchronous write,
// r0 hardwired to zero. Define REGFILE_BYPASS_EN to forward same-cycle WB data.
module id_regfile #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned NREGS = 32,
   parameter int unsigned AW    = $clog2(NREGS)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            we,
   input  logic [AW-1:0]   waddr,
   input  logic [XLEN-1:0] wdata,
   input  logic [AW-1:0]   raddr_a,
   output logic [XLEN-1:0] rdata_a,
   input  logic [AW-1:0]   raddr_b,
   output logic [XLEN-1:0] rdata_b
);

   logic [XLEN-1:0] regs_q [NREGS];
   logic            wr_en;

   assign wr_en = we && (waddr != '0);

   // Register array; entry 0 is never written so it stays zero.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < int'(NREGS); i++) regs_q[i] <= '0;
      end else if (wr_en) begin
         regs_q[waddr] <= wdata;
      end
   end

   // Read ports, with optional same-cycle forwarding of the WB write.
   always_comb begin
      rdata_a = regs_q[raddr_a];
      rdata_b = regs_q[raddr_b];
`ifdef REGFILE_BYPASS_EN
      if (wr_en && (waddr == raddr_a)) rdata_a = wdata;
      if (wr_en && (waddr == raddr_b)) rdata_b = wdata;
`endif
      if (raddr_a == '0) rdata_a = '0;
      if (raddr_b == '0) rdata_b = '0;
   end

endmodule

// File: rtl/id_stage_pipe.sv
// Decode stage: opcode decode, register read, load-use hazard detection and the
// ID/EXE pipeline register. REGFILE_BYPASS_EN selects WB->ID forwarding; without
// it, an ID read of the register WB is writing stalls one cycle instead.
module id_stage_pipe
   import id_pkg::*;
#(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned NREGS = 32,
   parameter int unsigned AW    = $clog2(NREGS)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            if_valid,
   input  logic [31:0]     if_instr,
   input  logic [XLEN-1:0] if_pc,
   input  logic            flush_in,
   input  logic            wb_we,
   input  logic [AW-1:0]   wb_dst,
   input  logic [XLEN-1:0] wb_data,
   output logic            stall_out,
   output logic            ex_valid,
   output ctrl_t           ex_ctrl,
   output logic [XLEN-1:0] ex_rs_data,
   output logic [XLEN-1:0] ex_rt_data,
   output logic [XLEN-1:0] ex_imm,
   output logic [XLEN-1:0] ex_pc,
   output logic [AW-1:0]   ex_rs_add,
   output logic [AW-1:0]   ex_rt_add,
   output logic [AW-1:0]   ex_rd_add,
   output logic [4:0]      ex_shamt,
   output logic [25:0]     ex_jaddr
);

   logic [5:0]      opcode;
   logic [AW-1:0]   rs, rt, rd;
   ctrl_t           ctrl;
   logic [XLEN-1:0] rs_data, rt_data, imm;
   logic            uses_rt, haz, bubble;

   logic            valid_d, valid_q;
   ctrl_t           ctrl_d, ctrl_q;
   logic [XLEN-1:0] rs_data_d, rs_data_q, rt_data_d, rt_data_q;
   logic [XLEN-1:0] imm_d, imm_q, pc_d, pc_q;
   logic [AW-1:0]   rs_d, rs_q, rt_d, rt_q, rd_d, rd_q;
   logic [4:0]      shamt_d, shamt_q;
   logic [25:0]     jaddr_d, jaddr_q;

   assign opcode = if_instr[31:26];
   assign rs     = if_instr[21 +: AW];
   assign rt     = if_instr[16 +: AW];
   assign rd     = if_instr[11 +: AW];
   assign ctrl   = decode_op(opcode);
   assign imm    = ctrl.ext_op ? {{(XLEN-16){if_instr[15]}}, if_instr[15:0]}
                               : {{(XLEN-16){1'b0}}, if_instr[15:0]};

   id_regfile #(
      .XLEN  (XLEN),
      .NREGS (NREGS),
      .AW    (AW)
   ) u_regfile (
      .clk     (clk),
      .rst     (rst),
      .we      (wb_we),
      .waddr   (wb_dst),
      .wdata   (wb_data),
      .raddr_a (rs),
      .rdata_a (rs_data),
      .raddr_b (rt),
      .rdata_b (rt_data)
   );

   // Hazard detection: load-use, plus WB-read collision when not forwarding.
   always_comb begin
      uses_rt = (opcode == OP_R) || (opcode == OP_SW) || (opcode == OP_BEQ);
      haz = valid_q && ctrl_q.mem_read && (rt_q != '0) && if_valid &&
            ((rt_q == rs) || ((rt_q == rt) && uses_rt));
`ifndef REGFILE_BYPASS_EN
      if (wb_we && (wb_dst != '0) && ((wb_dst == rs) || (wb_dst == rt))) haz = 1'b1;
`endif
      bubble = flush_in || haz;
      // Reset clears the stall combinationally; flush overrides a hazard.
      stall_out = rst && haz && !flush_in;
   end

   // Next ID/EXE contents: decoded fields, or an all-zero bubble.
   always_comb begin
      valid_d   = 1'b0;
      ctrl_d    = '0;
      rs_data_d = '0;
      rt_data_d = '0;
      imm_d     = '0;
      pc_d      = '0;
      rs_d      = '0;
      rt_d      = '0;
      rd_d      = '0;
      shamt_d   = '0;
      jaddr_d   = '0;
      if (!bubble) begin
         valid_d   = if_valid;
         ctrl_d    = ctrl;
         rs_data_d = rs_data;
         rt_data_d = rt_data;
         imm_d     = imm;
         pc_d      = if_pc;
         rs_d      = rs;
         rt_d      = rt;
         rd_d      = rd;
         shamt_d   = if_instr[10:6];
         jaddr_d   = if_instr[25:0];
      end
   end

   // ID/EXE pipeline register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q   <= 1'b0;
         ctrl_q    <= '0;
         rs_data_q <= '0;
         rt_data_q <= '0;
         imm_q     <= '0;
         pc_q      <= '0;
         rs_q      <= '0;
         rt_q      <= '0;
         rd_q      <= '0;
         shamt_q   <= '0;
         jaddr_q   <= '0;
      end else begin
         valid_q   <= valid_d;
         ctrl_q    <= ctrl_d;
         rs_data_q <= rs_data_d;
         rt_data_q <= rt_data_d;
         imm_q     <= imm_d;
         pc_q      <= pc_d;
         rs_q      <= rs_d;
         rt_q      <= rt_d;
         rd_q      <= rd_d;
         shamt_q   <= shamt_d;
         jaddr_q   <= jaddr_d;
      end
   end

   assign ex_valid   = valid_q;
   assign ex_ctrl    = ctrl_q;
   assign ex_rs_data = rs_data_q;
   assign ex_rt_data = rt_data_q;
   assign ex_imm     = imm_q;
   assign ex_pc      = pc_q;
   assign ex_rs_add  = rs_q;
   assign ex_rt_add  = rt_q;
   assign ex_rd_add  = rd_q;
   assign ex_shamt   = shamt_q;
   assign ex_jaddr   = jaddr_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe; expected values are hand-computed.
// Follows REGFILE_BYPASS_EN to pick the expected WB-collision behaviour.
module tb_id_stage_pipe;
   import id_pkg::*;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned NREGS = 32;
   localparam int unsigned AW    = 5;

   logic            clk = 1'b0;
   logic            rst;
   logic            if_valid;
   logic [31:0]     if_instr;
   logic [XLEN-1:0] if_pc;
   logic            flush_in;
   logic            wb_we;
   logic [AW-1:0]   wb_dst;
   logic [XLEN-1:0] wb_data;
   logic            stall_out;
   logic            ex_valid;
   ctrl_t           ex_ctrl;
   logic [XLEN-1:0] ex_rs_data, ex_rt_data, ex_imm, ex_pc;
   logic [AW-1:0]   ex_rs_add, ex_rt_add, ex_rd_add;
   logic [4:0]      ex_shamt;
   logic [25:0]     ex_jaddr;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   id_stage_pipe #(
      .XLEN  (XLEN),
      .NREGS (NREGS)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .if_valid   (if_valid),
      .if_instr   (if_instr),
      .if_pc      (if_pc),
      .flush_in   (flush_in),
      .wb_we      (wb_we),
      .wb_dst     (wb_dst),
      .wb_data    (wb_data),
      .stall_out  (stall_out),
      .ex_valid   (ex_valid),
      .ex_ctrl    (ex_ctrl),
      .ex_rs_data (ex_rs_data),
      .ex_rt_data (ex_rt_data),
      .ex_imm     (ex_imm),
      .ex_pc      (ex_pc),
      .ex_rs_add  (ex_rs_add),
      .ex_rt_add  (ex_rt_add),
      .ex_rd_add  (ex_rd_add),
      .ex_shamt   (ex_shamt),
      .ex_jaddr   (ex_jaddr)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock and settle just past the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Control words: {reg_dst,alu_src,branch,jump,mem_write,mem_read,mem_to_reg,
   // reg_write,alu_op[1:0],illegal,ext_op}
   localparam logic [11:0] C_R    = 12'h818;
   localparam logic [11:0] C_LW   = 12'h471;
   localparam logic [11:0] C_SW   = 12'h481;
   localparam logic [11:0] C_BEQ  = 12'h205;
   localparam logic [11:0] C_J    = 12'h100;
   localparam logic [11:0] C_ADDI = 12'h411;
   localparam logic [11:0] C_ORI  = 12'h41C;
   localparam logic [11:0] C_ILL  = 12'h002;

   localparam logic [31:0] I_LW_R2_R1  = 32'h8C22_0000; // lw  r2,0(r1)
   localparam logic [31:0] I_ADD_R5_R2 = 32'h0040_2820; // add r5,r2,r0

   initial begin
      rst = 1'b0; if_valid = 1'b1; if_instr = 32'h0063_2020; if_pc = 32'h4;
      flush_in = 1'b0; wb_we = 1'b0; wb_dst = '0; wb_data = '0;

      // Reset held while clocking with a valid instruction presented.
      repeat (3) tick();
      check("rst_ex_valid", ex_valid, 0);
      check("rst_ex_ctrl", ex_ctrl, 0);
      check("rst_ex_rs_data", ex_rs_data, 0);
      check("rst_ex_imm", ex_imm, 0);
      check("rst_ex_pc", ex_pc, 0);
      check("rst_stall", stall_out, 0);

      rst = 1'b1; if_valid = 1'b0; if_instr = '0; if_pc = '0;
      #1;
      // add r6,r5,r5: r5 reads zero after reset
      if_valid = 1'b1; if_instr = 32'h00A5_3020; if_pc = 32'h8;
      tick();
      check("r5_valid", ex_valid, 1);
      check("r5_rs_data", ex_rs_data, 0);
      check("r5_rd_add", ex_rd_add, 6);

      // WB r3=0x1234, then add r4,r3,r3
      if_valid = 1'b0; if_instr = '0; wb_we = 1'b1; wb_dst = 5'd3; wb_data = 32'h1234;
      tick();
      wb_we = 1'b0; if_valid = 1'b1; if_instr = 32'h0063_2020; if_pc = 32'h100;
      #1 check("add_stall", stall_out, 0);
      tick();
      check("add_valid", ex_valid, 1);
      check("add_rs_data", ex_rs_data, 32'h1234);
      check("add_rt_data", ex_rt_data, 32'h1234);
      check("add_aluop", ex_ctrl.alu_op, 2'b10);
      check("add_ctrl", ex_ctrl, C_R);
      check("add_pc", ex_pc, 32'h100);
      check("add_rd_add", ex_rd_add, 4);

      // Load-use: lw r2,0(r1); add r5,r2,r0
      if_instr = I_LW_R2_R1;
      tick();
      check("lw_ctrl", ex_ctrl, C_LW);
      check("lw_rt_add", ex_rt_add, 2);
      if_instr = I_ADD_R5_R2;
      #1 check("lu_stall", stall_out, 1);
      tick();
      check("lu_bubble_valid", ex_valid, 0);
      check("lu_bubble_ctrl", ex_ctrl, 0);
      check("lu_stall_clear", stall_out, 0);
      tick();
      check("lu_issue_valid", ex_valid, 1);
      check("lu_issue_rs_add", ex_rs_add, 2);
      check("lu_issue_rd_add", ex_rd_add, 5);

      // ori reads r2 only as rt, which is its destination: no stall
      if_instr = I_LW_R2_R1;
      tick();
      if_instr = 32'h3402_0005;
      #1 check("ori_rt_nostall", stall_out, 0);
      tick();
      check("ori_rt_valid", ex_valid, 1);

      // WB writes r7 while ID reads r7 (add r9,r7,r0)
      wb_we = 1'b1; wb_dst = 5'd7; wb_data = 32'hA5; if_instr = 32'h00E0_4820;
`ifdef REGFILE_BYPASS_EN
      #1 check("wbr_stall", stall_out, 0);
      tick();
      wb_we = 1'b0;
      check("wbr_valid", ex_valid, 1);
      check("wbr_rs_data", ex_rs_data, 32'hA5);
`else
      #1 check("wbr_stall", stall_out, 1);
      tick();
      wb_we = 1'b0;
      check("wbr_bubble", ex_valid, 0);
      #1 check("wbr_stall_clear", stall_out, 0);
      tick();
      check("wbr_valid", ex_valid, 1);
      check("wbr_rs_data", ex_rs_data, 32'hA5);
`endif

      // Immediate extension and decode of the remaining opcodes
      if_instr = 32'h340A_8000; // ori r10,r0,0x8000
      tick();
      check("ori_imm", ex_imm, 32'h0000_8000);
      check("ori_ctrl", ex_ctrl, C_ORI);
      if_instr = 32'h200B_8000; // addi r11,r0,0x8000
      tick();
      check("addi_imm", ex_imm, 32'hFFFF_8000);
      check("addi_ctrl", ex_ctrl, C_ADDI);
      if_instr = 32'hFC00_0000; // opcode 111111
      tick();
      check("ill_ctrl", ex_ctrl, C_ILL);
      check("ill_regwrite", ex_ctrl.reg_write, 0);
      check("ill_illegal", ex_ctrl.illegal, 1);
      if_instr = 32'hAC00_8000; // sw r0,0x8000(r0)
      tick();
      check("sw_ctrl", ex_ctrl, C_SW);
      check("sw_imm", ex_imm, 32'hFFFF_8000);
      if_instr = 32'h1000_0004; // beq r0,r0,4
      tick();
      check("beq_ctrl", ex_ctrl, C_BEQ);
      if_instr = 32'h0800_0123; // j 0x123
      tick();
      check("j_ctrl", ex_ctrl, C_J);
      check("j_jaddr", ex_jaddr, 26'h123);
      if_instr = 32'h0000_0140; // sll-form, shamt 5
      tick();
      check("shamt", ex_shamt, 5);

      // Flush together with a load-use hazard: flush wins
      if_instr = I_LW_R2_R1;
      tick();
      if_instr = I_ADD_R5_R2; flush_in = 1'b1;
      #1 check("fl_stall", stall_out, 0);
      tick();
      check("fl_valid", ex_valid, 0);
      check("fl_ctrl", ex_ctrl, 0);
      flush_in = 1'b0;
      tick();
      check("fl_next_valid", ex_valid, 1);
      check("fl_next_rs_add", ex_rs_add, 2);

      // Write to r0 is discarded, both same-cycle and afterwards
      if_instr = 32'h0000_3020; wb_we = 1'b1; wb_dst = 5'd0; wb_data = 32'hDEAD;
      #1 check("r0_stall", stall_out, 0);
      tick();
      wb_we = 1'b0;
      check("r0_same_rs", ex_rs_data, 0);
      tick();
      check("r0_after_rs", ex_rs_data, 0);
      check("r0_after_rt", ex_rt_data, 0);

      // Reset asserted mid-stall clears the stall immediately
      if_instr = I_LW_R2_R1;
      tick();
      if_instr = I_ADD_R5_R2;
      #1 check("mr_stall", stall_out, 1);
      rst = 1'b0;
      #1;
      check("mr_stall_clear", stall_out, 0);
      check("mr_valid", ex_valid, 0);
      check("mr_ctrl", ex_ctrl, 0);
      tick();
      rst = 1'b1; if_valid = 1'b0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
